// File: rtl/serial_slice_adder_pkg.sv
// Shared definitions for the serial slice adder: mode/state encodings and the
// one-bit full-adder cell used to build the ripple-carry slice.
package serial_slice_adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Returns {carry_out, sum} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/serial_slice_adder_rca_slice.sv
// Purely combinational W-bit ripple-carry slice; also exposes the carry into
// its top bit so the parent can derive signed overflow.
module rca_slice
  import serial_slice_adder_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/serial_slice_adder.sv
// Multi-cycle adder/subtractor: one shared SLICE-bit ripple slice processes the
// operands LSB-first over WIDTH/SLICE cycles behind a start/busy/done handshake.
module serial_slice_adder
  import serial_slice_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned KW = $clog2(N) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [SLICE-1:0] sl_s;
  logic             sl_cout, sl_cmsb;

  rca_slice #(.W(SLICE)) u_slice (
    .a     (a_q[SLICE-1:0]),
    .b     (b_q[SLICE-1:0]),
    .cin   (carry_q),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    k_d     = k_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (start) begin
          // Subtract is a + ~b + ~borrow_in.
          a_d     = a;
          b_d     = (mode == MODE_SUB) ? ~b : b;
          carry_d = cin ^ mode;
          res_d   = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        res_d   = (res_q >> SLICE) | (WIDTH'(sl_s) << (WIDTH - SLICE));
        carry_d = sl_cout;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(N - 1)) begin
          s_d     = res_d;
          cout_d  = sl_cout;
          ovf_d   = sl_cmsb ^ sl_cout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_slice_adder.sv
// Self-checking bench for serial_slice_adder: arithmetic reference model with a
// per-cycle compare on the 16/4 instance, plus directed runs on 8/8 and 8/1.
module tb_serial_slice_adder;

  localparam int N16 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, mode = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] s;

  logic       st8 [2];
  logic       md8 [2];
  logic       ci8 [2];
  logic [7:0] a8  [2];
  logic [7:0] b8  [2];
  logic [7:0] s8  [2];
  logic       bz8 [2];
  logic       dn8 [2];
  logic       co8 [2];
  logic       ov8 [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_slice_adder #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf));

  serial_slice_adder #(.WIDTH(8), .SLICE(8)) dut8w (
    .clk(clk), .rst_n(rst_n), .start(st8[0]), .mode(md8[0]), .a(a8[0]), .b(b8[0]), .cin(ci8[0]),
    .busy(bz8[0]), .done(dn8[0]), .s(s8[0]), .cout(co8[0]), .ovf(ov8[0]));

  serial_slice_adder #(.WIDTH(8), .SLICE(1)) dut8n (
    .clk(clk), .rst_n(rst_n), .start(st8[1]), .mode(md8[1]), .a(a8[1]), .b(b8[1]), .cin(ci8[1]),
    .busy(bz8[1]), .done(dn8[1]), .s(s8[1]), .cout(co8[1]), .ovf(ov8[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on w-bit operands; returns {cout, ovf, s}.
  function automatic logic [17:0] ref_op(input logic m, input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input int w);
    logic [16:0] r;
    logic [15:0] mask;
    logic        co, ov, sx, sy, sr;
    mask = (16'(1) << w) - 16'(1);
    if (!m) begin
      r  = 17'(x) + 17'(y) + 17'(c);
      co = r[w];
    end else begin
      r  = 17'(x) - 17'(y) - 17'(c);
      co = (17'(x) >= 17'(y) + 17'(c));
    end
    sx = x[w-1];
    sy = y[w-1];
    sr = r[w-1];
    ov = m ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
    return {co, ov, r[15:0] & mask};
  endfunction

  // Cycle-level model of the 16/4 instance: N16 cycles after capture the result appears.
  logic        m_busy = 0, m_done = 0, m_cout = 0, m_ovf = 0;
  logic [15:0] m_s = '0;
  logic [17:0] m_pend = '0;
  int          m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_cout = 0; m_ovf = 0; m_s = '0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == N16) begin
          m_busy = 0;
          m_done = 1;
          {m_cout, m_ovf, m_s} = m_pend;
        end
      end else if (start) begin
        m_pend = ref_op(mode, a, b, cin, 16);
        m_busy = 1;
        m_cnt  = 0;
      end
    end
  end

  always @(negedge clk)
    chk("cycle {busy,done,cout,ovf,s}", {12'b0, busy, done, cout, ovf, s},
        {12'b0, m_busy, m_done, m_cout, m_ovf, m_s});

  task automatic op16(input string nm, input logic m, input logic [15:0] x, input logic [15:0] y,
                      input logic c, input logic [15:0] es, input logic eco, input logic eov);
    int lat;
    @(negedge clk);
    start = 1; mode = m; a = x; b = y; cin = c;
    @(posedge clk);
    #1 start = 0; mode = ~m; a = ~x; b = ~y; cin = ~c;
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!done && lat < 20);
    chk({nm, " latency"}, 32'(lat), 32'(N16));
    chk({nm, " s"}, 32'(s), 32'(es));
    chk({nm, " cout"}, 32'(cout), 32'(eco));
    chk({nm, " ovf"}, 32'(ovf), 32'(eov));
  endtask

  task automatic run8(input string nm, input int i, input int exp_lat, input logic m,
                      input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic [7:0] es, input logic eco, input logic eov);
    int lat;
    @(negedge clk);
    st8[i] = 1; md8[i] = m; a8[i] = x; b8[i] = y; ci8[i] = c;
    @(posedge clk);
    #1 st8[i] = 0; a8[i] = ~x; b8[i] = ~y; md8[i] = ~m; ci8[i] = ~c;
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!dn8[i] && lat < 20);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " s"}, 32'(s8[i]), 32'(es));
    chk({nm, " cout"}, 32'(co8[i]), 32'(eco));
    chk({nm, " ovf"}, 32'(ov8[i]), 32'(eov));
  endtask

  initial begin
    int t, first_t, second_t;
    logic [15:0] first_s, second_s;
    logic [1:0]  second_flags;
    logic [17:0] r;

    for (int i = 0; i < 2; i++) begin
      st8[i] = 0; md8[i] = 0; ci8[i] = 0; a8[i] = '0; b8[i] = '0;
    end
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 chk("reset outputs", {12'b0, busy, done, cout, ovf, s}, 32'h0);
    #1 rst_n = 1;

    // Directed 16-bit arithmetic with hand-computed results.
    op16("add 1234+4321", 0, 16'h1234, 16'h4321, 0, 16'h5555, 0, 0);
    op16("add FFFF+0001", 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
    op16("add 7FFF+0001", 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    op16("add 00FF+0+cin", 0, 16'h00FF, 16'h0000, 1, 16'h0100, 0, 0);
    op16("sub 0005-0007", 1, 16'h0005, 16'h0007, 0, 16'hFFFE, 0, 0);
    op16("sub 0010-0001-1", 1, 16'h0010, 16'h0001, 1, 16'h000E, 1, 0);
    op16("sub 8000-0001", 1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] x, y;
      logic        m, c;
      x = 16'($urandom); y = 16'($urandom); m = 1'($urandom); c = 1'($urandom);
      r = ref_op(m, x, y, c, 16);
      op16("rand16", m, x, y, c, r[15:0], r[17], r[16]);
    end

    // start held through the run is ignored; start in the done cycle is accepted.
    @(negedge clk);
    start = 1; mode = 0; a = 16'h1111; b = 16'h2222; cin = 0;
    @(posedge clk);
    #1 mode = 1; a = 16'hAAAA; b = 16'h5555; cin = 0;
    first_t = -1; second_t = -1; first_s = '0; second_s = '0; second_flags = '0;
    for (t = 1; t <= 14; t++) begin
      @(posedge clk);
      if (t == 5) #1 start = 0;
      @(negedge clk);
      if (done) begin
        if (first_t < 0) begin
          first_t = t; first_s = s;
        end else if (second_t < 0) begin
          second_t = t; second_s = s; second_flags = {cout, ovf};
        end
      end
    end
    chk("b2b first done edge", 32'(first_t), 32'd4);
    chk("b2b first s", 32'(first_s), 32'h3333);
    chk("b2b second done edge", 32'(second_t), 32'd9);
    chk("b2b second s", 32'(second_s), 32'h5555);
    chk("b2b second cout/ovf", 32'(second_flags), 32'h3);

    // Reset mid-operation.
    @(negedge clk);
    start = 1; mode = 0; a = 16'h0F0F; b = 16'h0101; cin = 0;
    @(posedge clk);
    #1 start = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1 chk("mid-op reset outputs", {12'b0, busy, done, cout, ovf, s}, 32'h0);
    repeat (6) begin
      @(negedge clk);
      chk("no done in reset", 32'(done), 32'h0);
    end
    @(posedge clk);
    #2 rst_n = 1;
    op16("after reset 0F0F+0101", 0, 16'h0F0F, 16'h0101, 0, 16'h1010, 0, 0);

    // 8-bit instances: N=1 and N=8.
    for (int i = 0; i < 2; i++) begin
      int lt;
      lt = (i == 0) ? 1 : 8;
      run8("w8 add 34+21", i, lt, 0, 8'h34, 8'h21, 0, 8'h55, 0, 0);
      run8("w8 sub 05-07", i, lt, 1, 8'h05, 8'h07, 0, 8'hFE, 0, 0);
      run8("w8 sub 10-01-1", i, lt, 1, 8'h10, 8'h01, 1, 8'h0E, 1, 0);
      run8("w8 sub 80-01", i, lt, 1, 8'h80, 8'h01, 0, 8'h7F, 1, 1);
      run8("w8 add 7F+7F", i, lt, 0, 8'h7F, 8'h7F, 1, 8'hFF, 0, 1);
      for (int j = 0; j < 3; j++) begin
        logic [7:0] x, y;
        logic       m, c;
        x = 8'($urandom); y = 8'($urandom); m = 1'($urandom); c = 1'($urandom);
        r = ref_op(m, {8'h0, x}, {8'h0, y}, c, 8);
        run8("w8 rand", i, lt, m, x, y, c, r[7:0], r[17], r[16]);
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
